mem_bank_resp: RTL and testbench
================================

Name: mem_bank_resp

Overview:
- Memory-side responder for the data memory controller's bank interface: one instance per bank (A, B), answering the controller's read/write requests.
- Holds a DEPTH x DATA_W synchronous array. Accepts one request per cycle over a valid/ready handshake and returns read data through a fixed-latency response pipeline.
- After every reset, a clear FSM zero-fills the array before the first request is accepted.

Parameters:
- DATA_W, 8, data word width
- ADDR_W, 8, request address width
- DEPTH, 256, number of words; legal range 2..2^ADDR_W
- RD_LAT, 1, read latency in cycles from accept edge to resp_valid; legal values 1 or 2

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- req_ready  output  1  responder can accept a request this cycle
- resp_valid  output  1  read response valid (single-cycle pulse per read)
- resp_rdata  output  DATA_W  read data
- resp_err  output  1  qualifies resp_valid: address was out of range
- clear_busy  output  1  zero-fill in progress

Behaviour:
- Reset: one clock and one reset only; reset is synchronous and active-high, named clk and rst.
- Values while rst=1 and after rst is released:
  - state=CLEAR, clr_addr=0, clear_busy=1, req_ready=0
  - resp_valid=0, resp_err=0, resp_rdata=0
  - response pipeline flushed
- States: CLEAR, READY. No other states.
- CLEAR:
  - each cycle writes 0 to mem[clr_addr] and increments clr_addr.
  - on the edge that writes DEPTH-1, go to READY.
  - net effect: req_ready first reads 1 exactly DEPTH cycles after the first edge with rst=0.
  - requests presented while req_ready=0 are ignored, not queued.
- READY: req_ready=1, clear_busy=0. The block stays in READY until rst.
- Accept: the edge where req_valid & req_ready.
- Write accept:
  - mem[req_addr] <= req_wdata on the accept edge.
  - no response is generated.
  - a read of the same address accepted on the next cycle returns the new data.
- Read accept:
  - data captured from mem[req_addr] on the accept edge.
  - resp_valid=1 for exactly one cycle, RD_LAT cycles after the accept edge.
- Back-to-back reads: full throughput, one per cycle, responses in request order. There is no response backpressure; the controller must always sink responses.
- Out of range (req_addr >= DEPTH, only possible when DEPTH < 2^ADDR_W):
  - write is dropped; the array is unchanged.
  - read returns resp_rdata=0 with resp_err=1 alongside resp_valid.
- resp_rdata holds its last value while resp_valid=0.
- resp_err is 0 whenever resp_valid=0.
- Reset mid-operation:
  - in-flight reads are discarded; resp_valid=0 on the cycle after the rst edge.
  - the clear restarts from address 0 and contents are re-zeroed.
  - rst during CLEAR restarts the sweep.
- Write data, address and we are sampled only on the accept edge. Values on non-accept cycles have no effect.

Optional Feature:
- Macro MEM_ACCESS_CNT_EN.
- When defined, add two ports:
  - rd_count  output  16  count of accepted reads (in-range and out-of-range)
  - wr_count  output  16  count of accepted writes (in-range and out-of-range)
- Counter rules:
  - both reset to 0 on rst.
  - each increments on its accept edge.
  - each saturates at 16'hFFFF; there is no wrap.
  - clear-FSM writes are not counted.
- When not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Post-reset clear: rst high 3 cycles then low. Required: req_ready=0 and clear_busy=1 for exactly 256 cycles, then req_ready=1. A read of addr 8'h7F then returns 8'h00 with resp_err=0.
- Write then read (RD_LAT=1): write 8'hA5 to 8'h10, then read 8'h10 the next cycle. Required: resp_valid pulses 1 cycle after the read accept with resp_rdata=8'hA5. No resp_valid for the write.
- Streaming reads (RD_LAT=2): write 8'h01..8'h04 to addrs 0..3, then 4 consecutive reads of addrs 3,2,1,0. Required: 4 consecutive resp_valid cycles starting 2 cycles after the first accept, data 04,03,02,01.
- Out of range (DEPTH=200): write 8'hFF to addr 8'd210, then read 8'd210. Required: resp_rdata=0 and resp_err=1; a read of addr 8'd199 has resp_err=0.
- Reset mid-read: accept a read of addr 8'h10 holding 8'h5A, assert rst on the next edge. Required: no resp_valid appears. After the clear, a read of 8'h10 returns 8'h00.
- MEM_ACCESS_CNT_EN: 3 writes and 5 reads (one out of range). Required: wr_count=3, rd_count=5. After rst, both counters read 0.

Source files
------------

// File: rtl/mem_bank_resp.sv
// Per-bank SRAM responder: zero-filled after reset, read data RD_LAT cycles after accept; optional MEM_ACCESS_CNT_EN counters.
// req_ready stays low while the clear runs; responses have no backpressure and the controller must always sink them.
module mem_bank_resp #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              clear_busy
`ifdef MEM_ACCESS_CNT_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [0:0] {
      ST_CLEAR,
      ST_READY
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    clr_addr_q, clr_addr_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                mem_we;
   logic [IDX_W-1:0]    mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;

   logic                acc;
   logic                rd_acc;
   logic                wr_acc;
   logic                in_range;
   logic [IDX_W-1:0]    req_idx;
   logic [DATA_W-1:0]   rd_dat;

   logic                pipe_vld_q [RD_LAT];
   logic                pipe_vld_d [RD_LAT];
   logic                pipe_err_q [RD_LAT];
   logic                pipe_err_d [RD_LAT];
   logic [DATA_W-1:0]   pipe_dat_q [RD_LAT];
   logic [DATA_W-1:0]   pipe_dat_d [RD_LAT];

   // Upper address bits only matter for the range check; the array is indexed by the low bits.
   always_comb begin
      in_range = (32'(req_addr) < DEPTH);
      req_idx  = req_addr[IDX_W-1:0];
      acc      = req_valid & req_ready & ~rst;
      rd_acc   = acc & ~req_we;
      wr_acc   = acc & req_we;
      rd_dat   = in_range ? mem_q[req_idx] : '0;
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      req_ready  = 1'b0;
      clear_busy = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = clr_addr_q;
      mem_wdata  = '0;
      case (state_q)
         ST_CLEAR: begin
            clear_busy = 1'b1;
            mem_we     = 1'b1;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == IDX_W'(DEPTH - 1)) begin
               state_d    = ST_READY;
               clr_addr_d = '0;
            end
         end
         ST_READY: begin
            req_ready = 1'b1;
            if (wr_acc && in_range) begin
               mem_we    = 1'b1;
               mem_waddr = req_idx;
               mem_wdata = req_wdata;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // Each stage only loads on a valid input, so the last stage holds the previous read data.
   always_comb begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         pipe_vld_d[i] = 1'b0;
         pipe_err_d[i] = pipe_err_q[i];
         pipe_dat_d[i] = pipe_dat_q[i];
      end
      pipe_vld_d[0] = rd_acc;
      if (rd_acc) begin
         pipe_dat_d[0] = rd_dat;
         pipe_err_d[0] = ~in_range;
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         if (pipe_vld_q[i-1]) begin
            pipe_dat_d[i] = pipe_dat_q[i-1];
            pipe_err_d[i] = pipe_err_q[i-1];
         end
      end
   end

   always_comb begin
      resp_valid = pipe_vld_q[RD_LAT-1];
      resp_rdata = pipe_dat_q[RD_LAT-1];
      resp_err   = pipe_vld_q[RD_LAT-1] & pipe_err_q[RD_LAT-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            pipe_vld_q[i] <= 1'b0;
            pipe_err_q[i] <= 1'b0;
            pipe_dat_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_d[i];
            pipe_err_q[i] <= pipe_err_d[i];
            pipe_dat_q[i] <= pipe_dat_d[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

`ifdef MEM_ACCESS_CNT_EN
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (rd_acc && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
      if (wr_acc && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign rd_count = rd_cnt_q;
   assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_bank_resp.sv
// Bench for mem_bank_resp: bank A (DEPTH 256, RD_LAT 1) and bank B (DEPTH 200, RD_LAT 2) driven with directed steps.
// Expected reads are queued with their due cycle when issued and popped when resp_valid is seen.
module tb_mem_bank_resp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b;
   logic       a_vld, a_we, a_rdy, a_resp_vld, a_err, a_busy;
   logic [7:0] a_addr, a_wdata, a_rdata;
   logic       b_vld, b_we, b_rdy, b_resp_vld, b_err, b_busy;
   logic [7:0] b_addr, b_wdata, b_rdata;
`ifdef MEM_ACCESS_CNT_EN
   logic [15:0] a_rdc, a_wrc, b_rdc, b_wrc;
`endif

   mem_bank_resp #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RD_LAT(1)) dut_a (
      .clk(clk), .rst(rst_a), .req_valid(a_vld), .req_we(a_we), .req_addr(a_addr),
      .req_wdata(a_wdata), .req_ready(a_rdy), .resp_valid(a_resp_vld), .resp_rdata(a_rdata),
      .resp_err(a_err), .clear_busy(a_busy)
`ifdef MEM_ACCESS_CNT_EN
      , .rd_count(a_rdc), .wr_count(a_wrc)
`endif
   );

   mem_bank_resp #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RD_LAT(2)) dut_b (
      .clk(clk), .rst(rst_b), .req_valid(b_vld), .req_we(b_we), .req_addr(b_addr),
      .req_wdata(b_wdata), .req_ready(b_rdy), .resp_valid(b_resp_vld), .resp_rdata(b_rdata),
      .resp_err(b_err), .clear_busy(b_busy)
`ifdef MEM_ACCESS_CNT_EN
      , .rd_count(b_rdc), .wr_count(b_wrc)
`endif
   );

   typedef struct {
      logic [7:0] dat;
      logic       err;
      int         due;
   } exp_t;

   exp_t       q_a[$];
   exp_t       q_b[$];
   logic [7:0] model_a [256];
   logic [7:0] model_b [256];
   logic [7:0] last_a, last_b;
   int         exp_rd_b, exp_wr_b;
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         n;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic mon(input bit sel);
      logic       v, e;
      logic [7:0] d;
      exp_t       x;
      v = sel ? b_resp_vld : a_resp_vld;
      e = sel ? b_err : a_err;
      d = sel ? b_rdata : a_rdata;
      if (v) begin
         if ((sel ? q_b.size() : q_a.size()) == 0) begin
            check(sel ? "b_spurious_resp" : "a_spurious_resp", 32'(v), 32'd0);
         end else begin
            x = sel ? q_b.pop_front() : q_a.pop_front();
            check(sel ? "b_rdata" : "a_rdata", 32'(d), 32'(x.dat));
            check(sel ? "b_err" : "a_err", 32'(e), 32'(x.err));
            check(sel ? "b_latency" : "a_latency", 32'(cyc), 32'(x.due));
         end
      end else begin
         check(sel ? "b_err_idle" : "a_err_idle", 32'(e), 32'd0);
      end
   endtask

   always @(negedge clk) begin
      mon(1'b0);
      mon(1'b1);
   end

   task automatic issue(input bit sel, input bit we, input logic [7:0] addr, input logic [7:0] dat);
      exp_t x;
      bit   inr;
      @(negedge clk);
      a_vld = 1'b0;
      b_vld = 1'b0;
      if (!sel) begin
         a_vld = 1'b1; a_we = we; a_addr = addr; a_wdata = dat;
         check("a_ready", 32'(a_rdy), 32'd1);
      end else begin
         b_vld = 1'b1; b_we = we; b_addr = addr; b_wdata = dat;
         check("b_ready", 32'(b_rdy), 32'd1);
      end
      inr = sel ? (addr < 8'd200) : 1'b1;
      if (sel) begin
         if (we) exp_wr_b++;
         else    exp_rd_b++;
      end
      if (we) begin
         if (inr) begin
            if (sel) model_b[addr] = dat;
            else     model_a[addr] = dat;
         end
      end else begin
         x.dat = inr ? (sel ? model_b[addr] : model_a[addr]) : 8'h00;
         x.err = ~inr;
         x.due = cyc + (sel ? 2 : 1);
         if (sel) begin q_b.push_back(x); last_b = x.dat; end
         else     begin q_a.push_back(x); last_a = x.dat; end
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         a_vld = 1'b0;
         b_vld = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] ra, rd;
      rst_a = 1'b1; rst_b = 1'b1;
      a_vld = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_vld = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         model_a[i] = 8'h00;
         model_b[i] = 8'h00;
      end
      last_a = 8'h00; last_b = 8'h00;
      exp_rd_b = 0; exp_wr_b = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_a_ready", 32'(a_rdy), 32'd0);
      check("rst_a_busy", 32'(a_busy), 32'd1);
      check("rst_a_rvalid", 32'(a_resp_vld), 32'd0);
      check("rst_a_rdata", 32'(a_rdata), 32'd0);
      check("rst_b_ready", 32'(b_rdy), 32'd0);
      check("rst_b_busy", 32'(b_busy), 32'd1);
      check("rst_b_rdata", 32'(b_rdata), 32'd0);

      // Count sampled cycles with req_ready low, starting at the release point.
      rst_a = 1'b0; rst_b = 1'b0;
      n = 0;
      while (!b_rdy && n < 1000) begin n++; @(negedge clk); end
      check("b_clear_len", 32'(n), 32'd200);
      while (!a_rdy && n < 1000) begin
         check("a_busy_in_clear", 32'(a_busy), 32'd1);
         n++;
         @(negedge clk);
      end
      check("a_clear_len", 32'(n), 32'd256);
      check("a_busy_done", 32'(a_busy), 32'd0);
      check("b_busy_done", 32'(b_busy), 32'd0);

      issue(1'b0, 1'b0, 8'h7F, 8'h00);
      issue(1'b0, 1'b1, 8'h10, 8'hA5);
      issue(1'b0, 1'b0, 8'h10, 8'h00);
      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom_range(0, 255));
         rd = 8'($urandom_range(0, 255));
         issue(1'b0, 1'b1, ra, rd);
         issue(1'b0, 1'b0, ra, 8'h00);
         issue(1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'h00);
      end
      idle(4);
      check("a_rdata_hold", 32'(a_rdata), 32'(last_a));

      for (int i = 0; i < 4; i++) issue(1'b1, 1'b1, 8'(i), 8'(i + 1));
      for (int i = 3; i >= 0; i--) issue(1'b1, 1'b0, 8'(i), 8'h00);
      idle(4);
      check("b_rdata_hold", 32'(b_rdata), 32'h01);

      issue(1'b1, 1'b1, 8'd210, 8'hFF);
      issue(1'b1, 1'b0, 8'd210, 8'h00);
      issue(1'b1, 1'b0, 8'd199, 8'h00);
      issue(1'b1, 1'b1, 8'd255, 8'h3C);
      issue(1'b1, 1'b0, 8'd255, 8'h00);
      idle(4);
`ifdef MEM_ACCESS_CNT_EN
      check("b_wr_count", 32'(b_wrc), 32'(exp_wr_b));
      check("b_rd_count", 32'(b_rdc), 32'(exp_rd_b));
`endif

      issue(1'b1, 1'b1, 8'h10, 8'h5A);
      issue(1'b1, 1'b0, 8'h10, 8'h00);
      @(negedge clk);
      b_vld = 1'b0;
      rst_b = 1'b1;
      q_b.delete();
      for (int i = 0; i < 256; i++) model_b[i] = 8'h00;
      last_b = 8'h00; exp_rd_b = 0; exp_wr_b = 0;
      repeat (2) @(negedge clk);
      check("rst2_b_ready", 32'(b_rdy), 32'd0);
      check("rst2_b_busy", 32'(b_busy), 32'd1);
      check("rst2_b_rdata", 32'(b_rdata), 32'd0);
`ifdef MEM_ACCESS_CNT_EN
      check("rst2_b_wr_count", 32'(b_wrc), 32'd0);
      check("rst2_b_rd_count", 32'(b_rdc), 32'd0);
`endif
      rst_b = 1'b0;
      n = 0;
      while (!b_rdy && n < 1000) begin n++; @(negedge clk); end
      check("b_reclear_len", 32'(n), 32'd200);
      issue(1'b1, 1'b0, 8'h10, 8'h00);
      issue(1'b0, 1'b0, 8'h10, 8'h00);
      idle(5);

      check("a_queue_drained", 32'(q_a.size()), 32'd0);
      check("b_queue_drained", 32'(q_b.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
